// File: rtl/pwd_cracker_pkg.sv
// Shared constants, index-to-ASCII map and worker FSM encoding for the password cracker.
// Combinational helpers only; no state and no flow control.
package pwd_cracker_pkg;

  localparam int CHARSET_SIZE = 36;
  localparam int PWD_LEN      = 4;
  localparam int IDX_W        = 6;
  localparam int CHAR_W       = 8;
  localparam int CNT_W        = 21;
  localparam int PWD_W        = PWD_LEN * CHAR_W;

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(CHARSET_SIZE - 1);

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [CHAR_W-1:0] char_t;
  typedef logic [PWD_W-1:0]  pwd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FIN    = 2'd3
  } worker_state_t;

  // 0-25 -> 'a'-'z', 26-35 -> '0'-'9'
  function automatic char_t idx2ascii(input idx_t idx);
    if (idx < 6'd26) return 8'h61 + {2'b00, idx};
    else             return 8'h30 + {2'b00, idx} - 8'd26;
  endfunction

endpackage

// File: rtl/pwd_index_counter.sv
// Four-digit base-36 odometer: load seeds {from,0,0,0}, each enable steps the lowest digit.
// Indices are registered; last is combinational from the current count, no backpressure.
module pwd_index_counter
  import pwd_cracker_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   en,
  input  idx_t                   from_idx,
  input  idx_t                   to_idx,
  output idx_t [PWD_LEN-1:0]     idx,
  output logic                   last
);

  idx_t                to_q;
  idx_t [PWD_LEN-1:0]  nxt;
  logic                carry;

  // idx[PWD_LEN-1] is char0 (slowest), idx[0] is char3 (fastest)
  always_comb begin
    nxt   = idx;
    carry = 1'b1;
    for (int i = 0; i < PWD_LEN; i++) begin
      if (carry) begin
        if (idx[i] == IDX_MAX) begin
          nxt[i] = '0;
        end else begin
          nxt[i] = idx[i] + IDX_W'(1);
          carry  = 1'b0;
        end
      end
    end
  end

  always_comb begin
    last = (idx[PWD_LEN-1] == to_q);
    for (int i = 0; i < PWD_LEN - 1; i++) begin
      if (idx[i] != IDX_MAX) last = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx  <= '0;
      to_q <= '0;
    end else if (load) begin
      idx  <= {from_idx, {((PWD_LEN-1)*IDX_W){1'b0}}};
      to_q <= to_idx;
    end else if (en) begin
      idx  <= nxt;
    end
  end

endmodule

// File: rtl/range_search_worker.sv
// Brute-force range worker: one candidate per clock through index -> ASCII -> compare stages.
// Result for candidate k lands two edges after it is issued; start is ignored while busy.
module range_search_worker
  import pwd_cracker_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IDX_W-1:0]          from_idx,
  input  logic [IDX_W-1:0]          to_idx,
  input  logic [PWD_LEN*CHAR_W-1:0] target,
  input  logic                      abort,
  output logic                      busy,
  output logic                      found,
  output logic [PWD_LEN*CHAR_W-1:0] match_pwd,
  output logic                      done,
  output logic [CNT_W-1:0]          tried
);

  worker_state_t        state;
  pwd_t                 target_q;
  pwd_t                 cand_ascii;
  pwd_t                 s1_pwd;
  logic                 s0_vld;
  logic                 s1_vld;
  logic                 s1_hit;
  logic                 accept;
  logic                 range_ok;
  logic                 cnt_en;
  idx_t [PWD_LEN-1:0]   cnt_idx;
  logic                 cnt_last;

  assign accept   = start && ((state == ST_IDLE) || (state == ST_FIN));
  assign range_ok = (from_idx <= to_idx) && (to_idx <= IDX_MAX);
  assign cnt_en   = (state == ST_SEARCH) && s0_vld;
  assign s1_hit   = s1_vld && (s1_pwd == target_q);

  pwd_index_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .en       (cnt_en),
    .from_idx (from_idx),
    .to_idx   (to_idx),
    .idx      (cnt_idx),
    .last     (cnt_last)
  );

  always_comb begin
    cand_ascii = '0;
    for (int i = 0; i < PWD_LEN; i++) begin
      cand_ascii[i*CHAR_W +: CHAR_W] = idx2ascii(cnt_idx[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      found     <= 1'b0;
      done      <= 1'b0;
      match_pwd <= '0;
      tried     <= '0;
      target_q  <= '0;
      s0_vld    <= 1'b0;
      s1_vld    <= 1'b0;
      s1_pwd    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_FIN: begin
          if (start) begin
            found     <= 1'b0;
            done      <= 1'b0;
            tried     <= '0;
            match_pwd <= '0;
            target_q  <= target;
            busy      <= 1'b1;
            s1_vld    <= 1'b0;
            // A bad range issues nothing and retires from DRAIN on the next edge
            if (range_ok) begin
              state  <= ST_SEARCH;
              s0_vld <= 1'b1;
            end else begin
              state  <= ST_DRAIN;
              s0_vld <= 1'b0;
            end
          end
        end
        ST_SEARCH, ST_DRAIN: begin
          if (s1_vld) tried <= tried + CNT_W'(1);
          s1_pwd <= cand_ascii;
          s1_vld <= s0_vld;
          if (s0_vld && cnt_last) begin
            s0_vld <= 1'b0;
            state  <= ST_DRAIN;
          end
          // A match at the same edge as abort still reports the match
          if (s1_hit) begin
            found     <= 1'b1;
            match_pwd <= s1_pwd;
            done      <= 1'b1;
            busy      <= 1'b0;
            s0_vld    <= 1'b0;
            s1_vld    <= 1'b0;
            state     <= ST_FIN;
          end else if (abort || (state == ST_DRAIN)) begin
            done   <= 1'b1;
            busy   <= 1'b0;
            s0_vld <= 1'b0;
            s1_vld <= 1'b0;
            state  <= ST_FIN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
